hazard_scheduler: RTL
=====================

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low.
- i_valid  in  1  ID holds a valid instruction.
- operation  in  6  ID opcode, bits [31:26].
- funct  in  6  ID function field, bits [5:0].
- wire_A  in  5  ID rs.
- wire_B  in  5  ID rt.
- wire_dest  in  5  ID rd.
- i_branch_taken  in  1  branch/jump in EX resolved taken this cycle.
- i_step_en  in  1  pipeline advance enable (debug stepping); 0 freezes everything.
- o_pc_write  out  1  PC update enable.
- o_ifid_write  out  1  IF/ID register load enable.
- o_ifid_flush  out  1  clear IF/ID to NOP.
- o_idex_bubble  out  1  load NOP into ID/EX instead of ID instruction.
- o_halted  out  1  processor halted.
- o_stall_count  out  16  saturating count of stall cycles.

Function
REQ-003 The block SHALL keep a 3-entry issue shadow (EX, MEM, WB), each {dst[4:0], wr, is_load}, shifting on every cycle with i_step_en=1; a bubble enters as wr=0.
REQ-004 Destination decode SHALL be: op 000000 -> rd, wr=1; op 001xxx -> rt, wr=1; op 100xxx -> rt, wr=1, is_load=1; op 000011 -> 31, wr=1; all others wr=0; dst=0 forces wr=0.
REQ-005 Source use SHALL be: op 000000, 000100, 000101, 101xxx -> rs and rt; op 001xxx, 100xxx -> rs; 000010, 000011, 111111 -> none; register 0 never matches.
REQ-006 States SHALL be RUN, STALL, DRAIN, HALT; decisions are combinational within the cycle, state changes on the next edge.
REQ-007 RUN with hazard (REQ-015/016) and i_valid=1: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1; next state STALL.
REQ-008 STALL SHALL repeat REQ-007 outputs while the hazard persists and return to RUN with all enables 1, bubble 0, in the first cycle it clears.
REQ-009 i_branch_taken=1 SHALL force o_ifid_flush=1, o_idex_bubble=1, o_pc_write=1, state RUN, overriding any hazard or HALT decode in ID.
REQ-010 ID opcode 111111 with i_valid=1 and no hazard SHALL issue normally, then enter DRAIN with o_pc_write=0, o_ifid_write=0, o_idex_bubble=1.
REQ-011 DRAIN SHALL last until all shadow entries have wr=0 after the halt passes WB (exactly 3 cycles), then enter HALT.
REQ-012 HALT SHALL hold o_halted=1, o_pc_write=0, o_ifid_write=0, o_idex_bubble=1; it is left only by reset.
REQ-013 i_step_en=0 SHALL drive o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=0, and freeze shadow, state and counter.
REQ-014 o_stall_count SHALL increment once per cycle with i_step_en=1 spent in STALL or entering STALL, saturating at 16'hFFFF.

Reset
REQ-017 While reset=0: state RUN, shadow wr=0, o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=1, o_halted=0, o_stall_count=0.
REQ-018 Reset asserted mid-STALL, DRAIN or HALT SHALL return to RUN on the first edge after release with no residual bubbles.

Configuration
REQ-015 With macro HAZARD_FORWARD_EN defined, hazard SHALL be only: EX.wr && EX.is_load && EX.dst matches a used source (1-cycle load-use stall).
REQ-016 Without HAZARD_FORWARD_EN, hazard SHALL be any used source matching EX.dst or MEM.dst with wr=1; WB never causes a hazard (register file writes before read).

Structure
REQ-019 Opcode constants, state encoding and field widths SHALL live in shared package mips_pkg.
REQ-020 Destination/source decode (REQ-004/005) SHALL be one combinational sub-module dest_decoder, reused per shadow entry.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- FORWARD_EN: lw $2 in EX, ID add $3,$2,$4 -> 1 stall cycle, o_idex_bubble=1, o_stall_count=1.
- no FORWARD_EN: add $5 in EX, ID sub $6,$5,$1 -> 2 stall cycles, o_stall_count=2.
- hazard on $0 (lw $0 then add using $0) -> no stall.
- load-use stall with i_branch_taken=1 same cycle -> o_ifid_flush=1, o_pc_write=1, no stall, count unchanged.
- opcode 111111 in ID -> 3 DRAIN cycles, then o_halted=1; reset low 1 cycle -> o_halted=0, RUN.
- 70000 forced stall cycles -> o_stall_count=16'hFFFF; i_step_en=0 -> all outputs frozen.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode constants, field widths, FSM encoding and issue-shadow entry
// type for the hazard scheduler.
package mips_pkg;

    localparam int OP_W         = 6;
    localparam int REG_W        = 5;
    localparam int CNT_W        = 16;
    localparam int SHADOW_DEPTH = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    // Opcode groups keyed on operation[5:3]
    localparam logic [2:0] GRP_IMM   = 3'b001;
    localparam logic [2:0] GRP_LOAD  = 3'b100;
    localparam logic [2:0] GRP_STORE = 3'b101;

    localparam logic [REG_W-1:0] LINK_REG   = 5'd31;
    localparam logic [1:0]       DRAIN_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_DRAIN,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             wr;
        logic             is_load;
    } shadow_t;

    // True when a used, non-zero source register is written by a shadow entry
    function automatic logic reg_match(input logic [REG_W-1:0] src,
                                       input logic             use_src,
                                       input shadow_t          entry);
        return use_src && (src != '0) && entry.wr && (entry.dst == src);
    endfunction

endpackage

// File: rtl/dest_decoder.sv
// Combinational decode of an instruction into its shadow entry (destination,
// write flag, load flag) and which of rs/rt it reads.
module dest_decoder
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]  operation,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    output shadow_t          entry,
    output logic             use_rs,
    output logic             use_rt
);

    always_comb begin
        entry  = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;

        if (operation == OP_RTYPE) begin
            entry.dst = rd;
            entry.wr  = 1'b1;
        end else if (operation[5:3] == GRP_IMM) begin
            entry.dst = rt;
            entry.wr  = 1'b1;
        end else if (operation[5:3] == GRP_LOAD) begin
            entry.dst     = rt;
            entry.wr      = 1'b1;
            entry.is_load = 1'b1;
        end else if (operation == OP_JAL) begin
            entry.dst = LINK_REG;
            entry.wr  = 1'b1;
        end

        // $0 is hardwired, so a write to it never produces a value to wait for
        if (entry.dst == '0) begin
            entry.wr      = 1'b0;
            entry.is_load = 1'b0;
        end

        if ((operation == OP_RTYPE) || (operation == OP_BEQ) ||
            (operation == OP_BNE) || (operation[5:3] == GRP_STORE)) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
        end else if ((operation[5:3] == GRP_IMM) || (operation[5:3] == GRP_LOAD)) begin
            use_rs = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: stall/flush/halt control with a 3-stage issue shadow.
// Define HAZARD_FORWARD_EN to restrict hazards to the 1-cycle load-use case.
module hazard_scheduler
    import mips_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [OP_W-1:0]  operation,
    input  logic [5:0]       funct,
    input  logic [REG_W-1:0] wire_A,
    input  logic [REG_W-1:0] wire_B,
    input  logic [REG_W-1:0] wire_dest,
    input  logic             i_branch_taken,
    input  logic             i_step_en,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_count
);

    shadow_t                 id_entry;
    shadow_t                 issue_entry;
    shadow_t                 shadow_reg [SHADOW_DEPTH];
    logic [SHADOW_DEPTH-1:0] shadow_wr;
    logic                    use_a;
    logic                    use_b;
    logic                    hazard;
    logic                    stall;
    logic                    pc_write;
    logic                    ifid_write;
    logic                    ifid_flush;
    logic                    idex_bubble;
    state_t                  state_reg;
    state_t                  state_next;
    logic [1:0]              drain_cnt_reg;
    logic [1:0]              drain_cnt_next;
    logic [CNT_W-1:0]        stall_count_reg;
    logic                    unused_bits;

    assign unused_bits = ^{funct, shadow_reg[0], shadow_reg[1], shadow_reg[2]};

    dest_decoder u_id_decoder (
        .operation (operation),
        .rs        (wire_A),
        .rt        (wire_B),
        .rd        (wire_dest),
        .entry     (id_entry),
        .use_rs    (use_a),
        .use_rt    (use_b)
    );

`ifdef HAZARD_FORWARD_EN
    // Only a load in EX cannot be forwarded in time
    assign hazard = shadow_reg[0].is_load &&
                    (reg_match(wire_A, use_a, shadow_reg[0]) ||
                     reg_match(wire_B, use_b, shadow_reg[0]));
`else
    // WB is excluded: the register file writes in the first half-cycle
    assign hazard = reg_match(wire_A, use_a, shadow_reg[0]) ||
                    reg_match(wire_B, use_b, shadow_reg[0]) ||
                    reg_match(wire_A, use_a, shadow_reg[1]) ||
                    reg_match(wire_B, use_b, shadow_reg[1]);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < SHADOW_DEPTH; gi++) begin : g_shadow_wr
            assign shadow_wr[gi] = shadow_reg[gi].wr;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        stall          = 1'b0;

        case (state_reg)
            ST_RUN, ST_STALL: begin
                drain_cnt_next = '0;
                if (i_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_next  = ST_RUN;
                end else if (i_valid && hazard) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall       = 1'b1;
                    state_next  = ST_STALL;
                end else if (i_valid && (operation == OP_HALT)) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                // Third drain cycle: the halt sits in WB and nothing ahead still writes
                if ((drain_cnt_reg == DRAIN_LAST) && (shadow_wr == '0)) begin
                    state_next = ST_HALT;
                end else if (drain_cnt_reg != DRAIN_LAST) begin
                    drain_cnt_next = drain_cnt_reg + 2'd1;
                end
            end
            ST_HALT: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign issue_entry = (i_valid && !idex_bubble) ? id_entry : '0;

    always_comb begin
        o_pc_write    = pc_write;
        o_ifid_write  = ifid_write;
        o_ifid_flush  = ifid_flush;
        o_idex_bubble = idex_bubble;
        o_halted      = (state_reg == ST_HALT);
        if (!i_step_en) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_ifid_flush  = 1'b0;
            o_idex_bubble = 1'b0;
        end
        if (!reset) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_ifid_flush  = 1'b0;
            o_idex_bubble = 1'b1;
            o_halted      = 1'b0;
        end
    end

    assign o_stall_count = stall_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_RUN;
            drain_cnt_reg   <= '0;
            stall_count_reg <= '0;
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                shadow_reg[i] <= '0;
            end
        end else if (i_step_en) begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            if (stall && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
            shadow_reg[0] <= issue_entry;
            for (int i = 1; i < SHADOW_DEPTH; i++) begin
                shadow_reg[i] <= shadow_reg[i-1];
            end
        end
    end

endmodule
